// File: rtl/display_scan_ctrl.sv
// Scan controller for an 8-digit 7-segment display: 1-cycle registered outputs, no backpressure.
// New frames are staged and only swapped into the active buffers at the end of digit 8's slot.
module display_scan_ctrl #(
   parameter int DIV   = 50000,
   parameter int BLANK = 500
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Enable,
   input  logic        Load,
   input  logic [31:0] Digits_in,
   input  logic [7:0]  Mask_in,
   output logic [7:0]  Channal,
   output logic [3:0]  Data,
   output logic        Blank,
   output logic        Pending,
   output logic        Frame_done
);

   localparam int            PW        = $clog2(DIV);
   localparam logic [PW-1:0] LAST      = PW'(DIV - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK);

   logic [PW-1:0] presc, presc_nx;
   logic [31:0]   act_digits, stg_digits, digits_nx;
   logic [7:0]    act_mask, stg_mask, mask_nx, chan_nx;
   logic [2:0]    idx_nx;
   logic          slot_end, boundary, apply;

   // Data/Blank are derived from the next-cycle state so they switch together with Channal.
   always_comb begin
      slot_end  = Enable && (presc == LAST);
      boundary  = slot_end && (Channal == 8'd8);
      apply     = boundary && Pending;
      presc_nx  = presc;
      chan_nx   = Channal;
      if (slot_end) begin
         presc_nx = '0;
         chan_nx  = (Channal == 8'd8) ? 8'd1 : Channal + 8'd1;
      end else if (Enable) begin
         presc_nx = presc + PW'(1);
      end
      digits_nx = apply ? stg_digits : act_digits;
      mask_nx   = apply ? stg_mask : act_mask;
      idx_nx    = chan_nx[2:0] - 3'd1;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         presc      <= '0;
         Channal    <= 8'd1;
         Data       <= 4'd0;
         Blank      <= 1'b1;
         Pending    <= 1'b0;
         Frame_done <= 1'b0;
         act_digits <= '0;
         act_mask   <= 8'hFF;
         stg_digits <= '0;
         stg_mask   <= '0;
      end else begin
         presc      <= presc_nx;
         Channal    <= chan_nx;
         act_digits <= digits_nx;
         act_mask   <= mask_nx;
         Data       <= digits_nx[{idx_nx, 2'b00} +: 4];
         Blank      <= (presc_nx < BLANK_END) || mask_nx[idx_nx] || !Enable;
         Frame_done <= boundary;
         // A load on the boundary cycle keeps Pending set: the old staging is applied now,
         // the new frame waits for the next boundary.
         if (Load) begin
            stg_digits <= Digits_in;
            stg_mask   <= Mask_in;
            Pending    <= 1'b1;
         end else if (apply) begin
            Pending    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with DIV=8, BLANK=2 against a position-counter reference model.
module tb_display_scan_ctrl;

   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = 8 * DIV;

   logic        Clk = 1'b0;
   logic        Rst_n, Enable, Load;
   logic [31:0] Digits_in;
   logic [7:0]  Mask_in;
   logic [7:0]  Channal;
   logic [3:0]  Data;
   logic        Blank, Pending, Frame_done;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Model: t counts enabled cycles since reset; slot and prescaler follow arithmetically.
   int          t;
   logic [31:0] m_act_d, m_stg_d;
   logic [7:0]  m_act_m, m_stg_m;
   logic        m_pend, m_fd, m_en;

   display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .Load(Load),
      .Digits_in(Digits_in), .Mask_in(Mask_in),
      .Channal(Channal), .Data(Data), .Blank(Blank),
      .Pending(Pending), .Frame_done(Frame_done)
   );

   always #5 Clk = ~Clk;

   function automatic int e_chan();
      return (t / DIV) % 8 + 1;
   endfunction

   function automatic logic [3:0] e_data();
      int c = e_chan();
      return m_act_d[(c - 1) * 4 +: 4];
   endfunction

   function automatic logic e_blank();
      int c = e_chan();
      return ((t % DIV) < BLANK) || m_act_m[c - 1] || !m_en;
   endfunction

   task automatic model_reset();
      t = 0; m_act_d = '0; m_stg_d = '0; m_act_m = 8'hFF; m_stg_m = '0;
      m_pend = 1'b0; m_fd = 1'b0; m_en = 1'b1;
   endtask

   task automatic tick();
      @(posedge Clk);
      m_en = Enable;
      m_fd = Enable && ((t % FRAME) == FRAME - 1);
      if (m_fd && m_pend) begin
         m_act_d = m_stg_d; m_act_m = m_stg_m; m_pend = 1'b0;
      end
      if (Load) begin
         m_stg_d = Digits_in; m_stg_m = Mask_in; m_pend = 1'b1;
      end
      if (Enable) t++;
      cyc++;
      #1;
   endtask

   task automatic run_to(input int pos);
      for (int i = 0; i < 200 && (t % FRAME) != pos; i++) tick();
   endtask

   task automatic test_reset();
      Rst_n = 1'b1; Enable = 1'b0; Load = 1'b0; Digits_in = '0; Mask_in = '0;
      #3 Rst_n = 1'b0;
      #1 model_reset();
      n_checks++; if (Channal !== 8'd1) $display("FAIL reset_chan got %0d exp 1", Channal); else n_pass++;
      n_checks++; if (Data !== 4'd0) $display("FAIL reset_data got %0d exp 0", Data); else n_pass++;
      n_checks++; if (Blank !== 1'b1) $display("FAIL reset_blank got %b exp 1", Blank); else n_pass++;
      n_checks++; if (Pending !== 1'b0) $display("FAIL reset_pending got %b exp 0", Pending); else n_pass++;
      n_checks++; if (Frame_done !== 1'b0) $display("FAIL reset_fd got %b exp 0", Frame_done); else n_pass++;
      @(negedge Clk);
      Rst_n = 1'b1; Enable = 1'b1;
   endtask

   task automatic test_idle();
      int pulses = 0;
      int first = -1, last = -1;
      for (int i = 0; i < 130; i++) begin
         tick();
         n_checks++; if (Channal !== 8'(e_chan())) $display("FAIL idle_chan got %0d exp %0d", Channal, e_chan()); else n_pass++;
         n_checks++; if (Blank !== 1'b1) $display("FAIL idle_blank got %b exp 1", Blank); else n_pass++;
         n_checks++; if (Data !== 4'd0) $display("FAIL idle_data got %0d exp 0", Data); else n_pass++;
         n_checks++; if (Frame_done !== m_fd) $display("FAIL idle_fd got %b exp %b", Frame_done, m_fd); else n_pass++;
         if (Frame_done === 1'b1) begin
            pulses++;
            if (first < 0) first = cyc; else last = cyc;
         end
      end
      n_checks++; if (pulses != 2) $display("FAIL idle_pulses got %0d exp 2", pulses); else n_pass++;
      n_checks++; if (last - first != FRAME) $display("FAIL idle_period got %0d exp %0d", last - first, FRAME); else n_pass++;
   endtask

   task automatic test_load();
      bit seen = 0;
      run_to(20);
      Digits_in = 32'h8765_4321; Mask_in = 8'h00; Load = 1'b1;
      tick();
      Load = 1'b0;
      n_checks++; if (Pending !== 1'b1) $display("FAIL load_pending_set got %b exp 1", Pending); else n_pass++;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (Frame_done === 1'b1) begin seen = 1; break; end
         n_checks++; if (Pending !== 1'b1) $display("FAIL load_pending_hold got %b exp 1", Pending); else n_pass++;
      end
      n_checks++; if (!seen) $display("FAIL load_boundary got timeout exp Frame_done"); else n_pass++;
      n_checks++; if (Pending !== 1'b0) $display("FAIL load_pending_clr got %b exp 0", Pending); else n_pass++;
      n_checks++; if (Channal !== 8'd1) $display("FAIL load_chan1 got %0d exp 1", Channal); else n_pass++;
      n_checks++; if (Data !== 4'd1) $display("FAIL load_data1 got %0d exp 1", Data); else n_pass++;
      for (int i = 0; i < FRAME - 1; i++) begin
         tick();
         n_checks++; if (Data !== 4'(e_chan())) $display("FAIL load_data got %0d exp %0d", Data, e_chan()); else n_pass++;
         n_checks++; if (Blank !== ((t % DIV) < BLANK)) $display("FAIL load_blank got %b exp %b", Blank, (t % DIV) < BLANK); else n_pass++;
      end
   endtask

   task automatic test_mask();
      bit seen = 0;
      logic exp_b;
      Digits_in = 32'h8765_4321; Mask_in = 8'b0000_0100; Load = 1'b1;
      tick();
      Load = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (Frame_done === 1'b1) begin seen = 1; break; end
      end
      n_checks++; if (!seen) $display("FAIL mask_boundary got timeout exp Frame_done"); else n_pass++;
      for (int i = 0; i < FRAME; i++) begin
         exp_b = (e_chan() == 3) ? 1'b1 : ((t % DIV) < BLANK);
         n_checks++; if (Blank !== exp_b) $display("FAIL mask_blank got %b exp %b", Blank, exp_b); else n_pass++;
         n_checks++; if (Data !== 4'(e_chan())) $display("FAIL mask_data got %0d exp %0d", Data, e_chan()); else n_pass++;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a_v, b_v;
      int c;
      a_v = $urandom;
      b_v = ~a_v;
      Mask_in = 8'h00;
      run_to(FRAME - 3);
      Digits_in = a_v; Load = 1'b1;
      tick();
      Load = 1'b0;
      tick();
      Digits_in = b_v; Load = 1'b1;
      tick();
      Load = 1'b0;
      n_checks++; if (Frame_done !== 1'b1) $display("FAIL b2b_fd1 got %b exp 1", Frame_done); else n_pass++;
      n_checks++; if (Pending !== 1'b1) $display("FAIL b2b_pending got %b exp 1", Pending); else n_pass++;
      n_checks++; if (Data !== a_v[3:0]) $display("FAIL b2b_data_a1 got %0h exp %0h", Data, a_v[3:0]); else n_pass++;
      for (int i = 0; i < FRAME - 1; i++) begin
         tick();
         c = e_chan();
         n_checks++; if (Data !== a_v[(c - 1) * 4 +: 4]) $display("FAIL b2b_data_a got %0h exp %0h", Data, a_v[(c - 1) * 4 +: 4]); else n_pass++;
      end
      tick();
      n_checks++; if (Frame_done !== 1'b1) $display("FAIL b2b_fd2 got %b exp 1", Frame_done); else n_pass++;
      n_checks++; if (Pending !== 1'b0) $display("FAIL b2b_pending_clr got %b exp 0", Pending); else n_pass++;
      n_checks++; if (Data !== b_v[3:0]) $display("FAIL b2b_data_b1 got %0h exp %0h", Data, b_v[3:0]); else n_pass++;
   endtask

   task automatic test_enable();
      int start, n;
      bit seen = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (Frame_done === 1'b1) begin seen = 1; break; end
      end
      n_checks++; if (!seen) $display("FAIL en_sync got timeout exp Frame_done"); else n_pass++;
      start = cyc;
      run_to(4 * DIV + 4);
      Enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (Channal !== 8'd5) $display("FAIL en_hold_chan got %0d exp 5", Channal); else n_pass++;
         n_checks++; if (Blank !== 1'b1) $display("FAIL en_hold_blank got %b exp 1", Blank); else n_pass++;
      end
      Enable = 1'b1;
      n = 0;
      while (Channal !== 8'd6 && n < 12) begin tick(); n++; end
      n_checks++; if (n != 4) $display("FAIL en_resume_len got %0d exp 4", n); else n_pass++;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (Frame_done === 1'b1) begin seen = 1; break; end
      end
      n_checks++; if (!seen || cyc - start != FRAME + 5) $display("FAIL en_period got %0d exp %0d", cyc - start, FRAME + 5); else n_pass++;
   endtask

   task automatic test_async_reset();
      Mask_in = 8'h00;
      run_to(5 * DIV + 2);
      Digits_in = $urandom; Load = 1'b1;
      tick();
      Load = 1'b0;
      n_checks++; if (Pending !== 1'b1) $display("FAIL arst_pre_pending got %b exp 1", Pending); else n_pass++;
      #3 Rst_n = 1'b0;
      #1 model_reset();
      n_checks++; if (Channal !== 8'd1) $display("FAIL arst_chan got %0d exp 1", Channal); else n_pass++;
      n_checks++; if (Data !== 4'd0) $display("FAIL arst_data got %0d exp 0", Data); else n_pass++;
      n_checks++; if (Blank !== 1'b1) $display("FAIL arst_blank got %b exp 1", Blank); else n_pass++;
      n_checks++; if (Pending !== 1'b0) $display("FAIL arst_pending got %b exp 0", Pending); else n_pass++;
      n_checks++; if (Frame_done !== 1'b0) $display("FAIL arst_fd got %b exp 0", Frame_done); else n_pass++;
      #2;
      @(negedge Clk);
      Rst_n = 1'b1;
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
         tick();
         n_checks++; if (Blank !== 1'b1) $display("FAIL arst_after_blank got %b exp 1", Blank); else n_pass++;
         n_checks++; if (Data !== 4'd0) $display("FAIL arst_after_data got %0d exp 0", Data); else n_pass++;
         n_checks++; if (Pending !== 1'b0) $display("FAIL arst_after_pending got %b exp 0", Pending); else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 700; i++) begin
         Enable    = ($urandom % 16) != 0;
         Load      = ($urandom % 8) == 0;
         Digits_in = $urandom;
         Mask_in   = ($urandom % 2) ? 8'h00 : 8'($urandom);
         tick();
         n_checks++; if (Channal !== 8'(e_chan())) $display("FAIL rnd_chan got %0d exp %0d", Channal, e_chan()); else n_pass++;
         n_checks++; if (Data !== e_data()) $display("FAIL rnd_data got %0h exp %0h", Data, e_data()); else n_pass++;
         n_checks++; if (Blank !== e_blank()) $display("FAIL rnd_blank got %b exp %b", Blank, e_blank()); else n_pass++;
         n_checks++; if (Pending !== m_pend) $display("FAIL rnd_pending got %b exp %b", Pending, m_pend); else n_pass++;
         n_checks++; if (Frame_done !== m_fd) $display("FAIL rnd_fd got %b exp %b", Frame_done, m_fd); else n_pass++;
      end
      Enable = 1'b1; Load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_load();
      test_mask();
      test_back_to_back();
      test_enable();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
